// File: rtl/neuronio_pkg.sv
// Shared constants, state encoding and saturation helper for the neuronio MAC core.
package neuronio_pkg;

  localparam int ACC_W    = 32;
  localparam int IN_W     = 8;
  localparam int FRAC_IN  = 5;
  localparam int FRAC_ACC = 20;

  localparam logic [ACC_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [ACC_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Clamp a 33-bit signed sum to the 32-bit range; overflow shows as bit32 != bit31.
  function automatic logic [ACC_W-1:0] sat32(input logic [ACC_W:0] sum);
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      if (sum[ACC_W]) begin
        return SAT_MIN;
      end else begin
        return SAT_MAX;
      end
    end else begin
      return sum[ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/neuronio_mac_sat_add32.sv
// Combinational 32-bit signed saturating adder used by the neuron accumulator.
module sat_add32
  import neuronio_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] y
);

  logic [ACC_W:0] sum_s;

  assign sum_s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
  assign y     = sat32(sum_s);

endmodule

// File: rtl/neuronio_mac.sv
// Sequential MAC neuron: streams N_IN Q3.5 x/w pairs, adds a Q3.5 bias and
// presents a saturated Q12.20 pre-activation word under a valid/ready handshake.
module neuronio_mac
  import neuronio_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic [IN_W-1:0]   iBias,
  input  logic [IN_W-1:0]   iX,
  input  logic [IN_W-1:0]   iW,
  input  logic              iValid,
  output logic              oReady,
  output logic [ACC_W-1:0]  oA,
  output logic              oValid,
  input  logic              iReady,
  output logic              oBusy
);

  localparam int CNT_W = $clog2(N_IN + 1);

  state_e                state_r;
  state_e                state_nxt_s;
  logic [ACC_W-1:0]      acc_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  beat_s;
  logic                  last_s;
  logic signed [15:0]    prod_s;
  logic [ACC_W-1:0]      addend_s;
  logic [ACC_W-1:0]      bias_ext_s;
  logic [ACC_W-1:0]      sum_s;

  assign beat_s = iValid && (state_r == ACC);
  assign last_s = (cnt_r == CNT_W'(N_IN - 1));
  assign prod_s = $signed(iX) * $signed(iW);

  // Q6.10 product and Q3.5 bias realigned to the Q12.20 accumulator.
  assign addend_s   = {{6{prod_s[15]}}, prod_s, 10'b0};
  assign bias_ext_s = {{9{iBias[IN_W-1]}}, iBias, 15'b0};

  sat_add32 u_sat_add (
    .a (acc_r),
    .b (addend_s),
    .y (sum_s)
  );

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; iStart only matters in IDLE, iReady only in HOLD.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (iStart) begin
          state_nxt_s = ACC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
        if (beat_s && last_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = ACC;
        end
      end
      HOLD: begin
        if (iReady) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Accumulator and beat counter; acc is left untouched through HOLD and IDLE.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if ((state_r == IDLE) && iStart) begin
      acc_r <= bias_ext_s;
      cnt_r <= '0;
    end else if (beat_s) begin
      acc_r <= sum_s;
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  assign oReady = (state_r == ACC);
  assign oValid = (state_r == HOLD);
  assign oBusy  = (state_r != IDLE);
  assign oA     = acc_r;

endmodule

// File: tb/tb_neuronio_mac.sv
// Randomized self-checking bench for neuronio_mac against an arithmetic reference model.
module tb_neuronio_mac;

  logic        iClk;
  logic        iRst_n;
  logic        iStart, iValid, iReady;
  logic [7:0]  iBias, iX, iW;
  logic        oReady, oValid, oBusy;
  logic [31:0] oA;

  logic        s_iStart, s_iValid, s_iReady;
  logic [7:0]  s_iBias, s_iX, s_iW;
  logic        s_oReady, s_oValid, s_oBusy;
  logic [31:0] s_oA;

  int total = 0;
  int bad   = 0;

  neuronio_mac #(.N_IN(4)) u_dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iBias(iBias),
    .iX(iX), .iW(iW), .iValid(iValid), .oReady(oReady),
    .oA(oA), .oValid(oValid), .iReady(iReady), .oBusy(oBusy)
  );

  neuronio_mac #(.N_IN(400)) u_sat (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(s_iStart), .iBias(s_iBias),
    .iX(s_iX), .iW(s_iW), .iValid(s_iValid), .oReady(s_oReady),
    .oA(s_oA), .oValid(s_oValid), .iReady(s_iReady), .oBusy(s_oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reference: exact sum clamped to signed 32-bit after every beat.
  function automatic longint mac_step(input longint a, input logic [7:0] x, input logic [7:0] w);
    longint r;
    r = a + longint'($signed(x)) * longint'($signed(w)) * 64'sd1024;
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    else if (r < -64'sd2147483648) r = -64'sd2147483648;
    return r;
  endfunction

  task automatic test_reset();
    iRst_n = 1'b0;
    #2;
    total++;
    if (oA !== 32'h0 || oValid !== 1'b0 || oReady !== 1'b0 || oBusy !== 1'b0) begin
      bad++;
      $display("FAIL reset_init oA=%h v=%b r=%b b=%b required 0/0/0/0", oA, oValid, oReady, oBusy);
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    iReady = 1'b1;
    repeat (3) @(negedge iClk);
    total++;
    if (oBusy !== 1'b0 || oValid !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready_ignored busy=%b valid=%b required 0/0", oBusy, oValid);
    end
    iReady = 1'b0;
  endtask

  // mode 0: 20*20 pairs, 1: 10*C0 pairs, 2: random pairs.
  task automatic run_eval(input string name, input logic [7:0] bias, input int mode,
                          input int max_gap, input int hold_cyc, input bit start_on_exit);
    longint m;
    logic [7:0] x, w;
    int gap;
    m = longint'($signed(bias)) * 64'sd32768;
    iBias  = bias;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    total++;
    if (oBusy !== 1'b1 || oReady !== 1'b1 || oValid !== 1'b0 || oA !== 32'(m)) begin
      bad++;
      $display("FAIL %s_start oA=%h busy=%b rdy=%b required %h/1/1", name, oA, oBusy, oReady, 32'(m));
    end
    for (int b = 0; b < 4; b++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
      for (int g = 0; g < gap; g++) begin
        iValid = 1'b0;
        iX     = 8'($urandom);
        iStart = 1'b1;
        @(negedge iClk);
        total++;
        if (oA !== 32'(m) || oValid !== 1'b0 || oReady !== 1'b1) begin
          bad++;
          $display("FAIL %s_gap oA=%h v=%b r=%b required %h/0/1", name, oA, oValid, oReady, 32'(m));
        end
      end
      case (mode)
        0: begin x = 8'h20; w = 8'h20; end
        1: begin x = 8'h10; w = 8'hC0; end
        default: begin x = 8'($urandom); w = 8'($urandom); end
      endcase
      iX = x; iW = w; iValid = 1'b1; iStart = 1'b1;
      @(negedge iClk);
      iValid = 1'b0;
      iStart = 1'b0;
      m = mac_step(m, x, w);
      total++;
      if (oA !== 32'(m) || oValid !== (b == 3)) begin
        bad++;
        $display("FAIL %s_beat%0d oA=%h v=%b required %h/%b", name, b, oA, oValid, 32'(m), (b == 3));
      end
    end
    for (int h = 0; h < hold_cyc; h++) begin
      iValid = 1'b1;
      iX = 8'($urandom); iW = 8'($urandom);
      iStart = 1'b1;
      iReady = 1'b0;
      @(negedge iClk);
      total++;
      if (oValid !== 1'b1 || oReady !== 1'b0 || oA !== 32'(m)) begin
        bad++;
        $display("FAIL %s_hold oA=%h v=%b r=%b required %h/1/0", name, oA, oValid, oReady, 32'(m));
      end
    end
    iValid = 1'b0;
    iStart = start_on_exit;
    iReady = 1'b1;
    @(negedge iClk);
    iReady = 1'b0;
    iStart = 1'b0;
    total++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oA !== 32'(m)) begin
      bad++;
      $display("FAIL %s_exit oA=%h v=%b busy=%b required %h/0/0", name, oA, oValid, oBusy, 32'(m));
    end
    @(negedge iClk);
    total++;
    if (oBusy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle busy=%b required 0", name, oBusy);
    end
  endtask

  task automatic test_positive();
    run_eval("pos", 8'h20, 0, 0, 0, 1'b0);
    total++;
    if (oA !== 32'h0050_0000) begin
      bad++;
      $display("FAIL pos_value oA=%h required 00500000", oA);
    end
  endtask

  task automatic test_negative();
    run_eval("neg", 8'hE0, 1, 0, 1, 1'b0);
    total++;
    if (oA !== 32'hFFB0_0000) begin
      bad++;
      $display("FAIL neg_value oA=%h required ffb00000", oA);
    end
  endtask

  task automatic test_backpressure();
    run_eval("bp_fixed", 8'h20, 0, 3, 5, 1'b0);
    for (int i = 0; i < 4; i++) run_eval("bp_rand", 8'($urandom), 2, 3, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_eval("b2b_a", 8'($urandom), 2, 0, 0, 1'b0);
    run_eval("b2b_b", 8'($urandom), 2, 0, 0, 1'b1);
    run_eval("b2b_c", 8'($urandom), 2, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    iBias = 8'h40; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    iX = 8'h7F; iW = 8'h7F; iValid = 1'b1;
    repeat (2) @(negedge iClk);
    #2;
    iRst_n = 1'b0;
    #1;
    total++;
    if (oA !== 32'h0 || oValid !== 1'b0 || oReady !== 1'b0 || oBusy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid oA=%h v=%b r=%b b=%b required 0/0/0/0", oA, oValid, oReady, oBusy);
    end
    iValid = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);
    run_eval("post_rst", 8'h20, 0, 0, 2, 1'b0);
    total++;
    if (oA !== 32'h0050_0000) begin
      bad++;
      $display("FAIL post_rst_value oA=%h required 00500000", oA);
    end
  endtask

  task automatic test_saturation();
    longint m;
    logic [7:0] w;
    m = 0;
    s_iBias = 8'h00; s_iStart = 1'b1;
    @(negedge iClk);
    s_iStart = 1'b0;
    for (int b = 0; b < 400; b++) begin
      w = (b < 129) ? 8'h80 : 8'h7F;
      s_iX = 8'h80; s_iW = w; s_iValid = 1'b1;
      @(negedge iClk);
      m = mac_step(m, 8'h80, w);
      total++;
      if (s_oA !== 32'(m) || s_oValid !== (b == 399)) begin
        bad++;
        $display("FAIL sat_beat%0d oA=%h v=%b required %h/%b", b, s_oA, s_oValid, 32'(m), (b == 399));
      end
      if (b == 128) begin
        total++;
        if (s_oA !== 32'h7FFF_FFFF) begin
          bad++;
          $display("FAIL sat_pos oA=%h required 7fffffff", s_oA);
        end
      end
    end
    s_iValid = 1'b0;
    total++;
    if (s_oA !== 32'h8000_0000) begin
      bad++;
      $display("FAIL sat_neg oA=%h required 80000000", s_oA);
    end
    s_iReady = 1'b1;
    @(negedge iClk);
    s_iReady = 1'b0;
    total++;
    if (s_oBusy !== 1'b0) begin
      bad++;
      $display("FAIL sat_exit busy=%b required 0", s_oBusy);
    end
  endtask

  initial begin
    iStart = 1'b0; iValid = 1'b0; iReady = 1'b0;
    iBias = 8'h00; iX = 8'h00; iW = 8'h00;
    s_iStart = 1'b0; s_iValid = 1'b0; s_iReady = 1'b0;
    s_iBias = 8'h00; s_iX = 8'h00; s_iW = 8'h00;
    test_reset();
    test_positive();
    test_negative();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
